// File: rtl/cpu_clock_controller.sv
// cpu_clock_controller
//   Derives the processor virtual clock from physical_clock. Supports free-run,
//   pause (completes the current period first) and single-step. Both board keys
//   are synchronised and debounced here; a debounced press yields a 1-cycle event.
//
//   Optional feature: define CLKCTL_BREAK_EN to add a PC breakpoint that pauses
//   the clock at the period wrap when pc_pos matches bp_addr.
//
// Ports
//   physical_clock  in   board clock, the only clock
//   n_reset         in   asynchronous active-low reset
//   clk_sel[3:0]    in   speed select (0..3 pick P0..P3, >=4 picks P4)
//   run_key_n       in   raw active-low key, a press toggles run/pause
//   step_key_n      in   raw active-low key, a press while paused runs one period
//   pc_pos[15:0]    in   current PC (CLKCTL_BREAK_EN only)
//   bp_addr[15:0]   in   breakpoint address (CLKCTL_BREAK_EN only)
//   bp_valid        in   breakpoint enable (CLKCTL_BREAK_EN only)
//   bp_hit          out  set when a breakpoint paused the clock (CLKCTL_BREAK_EN only)
//   clock           out  registered virtual clock
//   clock_tick      out  1-cycle pulse in the cycle clock becomes 1
//   running         out  free-running (including a pending pause)
//   paused          out  held in pause
module cpu_clock_controller #(
    parameter int unsigned P0              = 16,
    parameter int unsigned P1              = 50000,
    parameter int unsigned P2              = 500000,
    parameter int unsigned P3              = 5000000,
    parameter int unsigned P4              = 50000000,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic        physical_clock,
    input  logic        n_reset,
    input  logic [3:0]  clk_sel,
    input  logic        run_key_n,
    input  logic        step_key_n,
`ifdef CLKCTL_BREAK_EN
    input  logic [15:0] pc_pos,
    input  logic [15:0] bp_addr,
    input  logic        bp_valid,
    output logic        bp_hit,
`endif
    output logic        clock,
    output logic        clock_tick,
    output logic        running,
    output logic        paused
);

    localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {StRun, StPausePend, StPause, StStep} state_e;

    // ---------------- key synchronisers and debouncers (bit 0 run, bit 1 step)
    logic [1:0]          key_raw;
    logic [1:0]          sync1_q, sync2_q;
    logic [1:0]          level_q, level_d;
    logic [1:0]          press_q;
    logic [1:0][DbW-1:0] stable_q, stable_d;

    assign key_raw = {step_key_n, run_key_n};

    always_comb begin
        level_d  = level_q;
        stable_d = '0;
        for (int k = 0; k < 2; k++) begin
            // Count consecutive samples that disagree with the accepted level;
            // the last one of DEBOUNCE_CYCLES flips the level.
            if (sync2_q[k] != level_q[k]) begin
                if (stable_q[k] == DbW'(DEBOUNCE_CYCLES - 1)) begin
                    level_d[k] = sync2_q[k];
                end else begin
                    stable_d[k] = stable_q[k] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge physical_clock or negedge n_reset) begin
        if (!n_reset) begin
            sync1_q  <= '1;
            sync2_q  <= '1;
            level_q  <= '1;
            stable_q <= '0;
            press_q  <= '0;
        end else begin
            sync1_q  <= key_raw;
            sync2_q  <= sync1_q;
            level_q  <= level_d;
            stable_q <= stable_d;
            press_q  <= level_q & ~level_d;
        end
    end

    logic run_press, step_press;
    assign run_press  = press_q[0];
    assign step_press = press_q[1];

    // ---------------- period select
    logic [31:0] sel_period;

    always_comb begin
        sel_period = P4;
        unique case (clk_sel)
            4'd0:    sel_period = P0;
            4'd1:    sel_period = P1;
            4'd2:    sel_period = P2;
            4'd3:    sel_period = P3;
            default: sel_period = P4;
        endcase
    end

    // ---------------- period counter and FSM
    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] period_q, period_d;
    logic        clock_q, clock_d;
    logic        tick_q, tick_d;
    logic        wrap;
`ifdef CLKCTL_BREAK_EN
    logic        bp_hit_q, bp_hit_d;
`endif

    assign wrap = (cnt_q == period_q - 32'd1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
`ifdef CLKCTL_BREAK_EN
        bp_hit_d = bp_hit_q;
`endif
        // The period in force is only replaced at a wrap, so a mid-period
        // clk_sel change takes effect from the next period.
        if (state_q != StPause) begin
            if (wrap) begin
                cnt_d    = '0;
                period_d = sel_period;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end

        unique case (state_q)
            StRun: begin
`ifdef CLKCTL_BREAK_EN
                if (wrap && bp_valid && (pc_pos == bp_addr)) begin
                    state_d  = StPause;
                    bp_hit_d = 1'b1;
                end else
`endif
                if (run_press) begin
                    state_d = StPausePend;
                end
            end
            StPausePend: begin
                if (wrap) state_d = StPause;
            end
            StPause: begin
                cnt_d = '0;
                if (run_press) begin
                    state_d  = StRun;
                    period_d = sel_period;
`ifdef CLKCTL_BREAK_EN
                    bp_hit_d = 1'b0;
`endif
                end else if (step_press) begin
                    state_d  = StStep;
                    period_d = sel_period;
                end
            end
            StStep: begin
                // Key events are ignored until the stepped period completes.
                if (wrap) state_d = StPause;
            end
            default: state_d = StRun;
        endcase

        // Clock is a function of the next count so it stays aligned with cnt_q.
        clock_d = (cnt_d >= (period_d >> 1));
        tick_d  = clock_d & ~clock_q;
    end

    always_ff @(posedge physical_clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q  <= StRun;
            cnt_q    <= '0;
            period_q <= P0;
            clock_q  <= 1'b0;
            tick_q   <= 1'b0;
`ifdef CLKCTL_BREAK_EN
            bp_hit_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            clock_q  <= clock_d;
            tick_q   <= tick_d;
`ifdef CLKCTL_BREAK_EN
            bp_hit_q <= bp_hit_d;
`endif
        end
    end

    assign clock      = clock_q;
    assign clock_tick = tick_q;
    assign running    = (state_q == StRun) || (state_q == StPausePend);
    assign paused     = (state_q == StPause);
`ifdef CLKCTL_BREAK_EN
    assign bp_hit     = bp_hit_q;
`endif

endmodule
